// File: rtl/peripheral_mult_seq.sv
// peripheral_mult_seq: memory-mapped sequential (shift-add, radix-2) multiplier
// on the J1 16-bit I/O bus. Operands are the low WIDTH bits of the A and B
// registers; the product is delivered as a 32-bit RES_HI/RES_LO pair.
// Optional signed mode works on magnitudes and re-applies the sign at the end.
module peripheral_mult_seq #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   output logic        irq
);

   // Product width and bit-counter width.
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [PW-1:0]    ONE_P = PW'(1);

   // FSM encoding.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Register map.
   localparam logic [3:0] ADDR_A      = 4'h0;
   localparam logic [3:0] ADDR_B      = 4'h2;
   localparam logic [3:0] ADDR_CTRL   = 4'h4;
   localparam logic [3:0] ADDR_STATUS = 4'h6;
   localparam logic [3:0] ADDR_RES_HI = 4'h8;
   localparam logic [3:0] ADDR_RES_LO = 4'hA;

   // Bus-visible registers.
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        ie_q, ie_d;
   logic        sgn_q, sgn_d;
   logic        ovr_q, ovr_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;
   logic [15:0] dout_q, dout_d;

   // Engine state.
   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             mode_q, mode_d;

   // Bus decode.
   logic wr_en, rd_en;
   logic wr_a, wr_b, wr_ctrl;
   logic start_req, busy, overrun;
   logic mode_new;

   assign wr_en     = cs && wr;
   assign rd_en     = cs && rd;
   assign wr_a      = wr_en && (addr == ADDR_A);
   assign wr_b      = wr_en && (addr == ADDR_B);
   assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
   assign busy      = (state_q == S_CALC);
   assign start_req = wr_ctrl && d_in[0];
   assign overrun   = start_req && busy;
   // The signed bit of the start write itself selects the mode of that run.
   assign mode_new  = SIGNED_EN & d_in[1];

   // Operand preparation: in signed mode take magnitudes and remember the sign.
   // The most-negative value negates to itself, which is its correct magnitude
   // when read as unsigned.
   logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;
   logic             neg_a, neg_b;

   assign op_a  = a_q[WIDTH-1:0];
   assign op_b  = b_q[WIDTH-1:0];
   assign neg_a = mode_new & op_a[WIDTH-1];
   assign neg_b = mode_new & op_b[WIDTH-1];
   assign mag_a = neg_a ? (~op_a + ONE_W) : op_a;
   assign mag_b = neg_b ? (~op_b + ONE_W) : op_b;

   // Shift-add step and final sign restoration.
   logic [PW-1:0] add_term, acc_sum, prod_final;
   logic [31:0]   result_ext;
   logic          last_bit;

   assign add_term   = mplier_q[0] ? mcand_q : '0;
   assign acc_sum    = acc_q + add_term;
   assign last_bit   = (cnt_q == CW'(1));
   assign prod_final = neg_q ? (~acc_sum + ONE_P) : acc_sum;
   assign result_ext = mode_q ? 32'(signed'(prod_final)) : 32'(prod_final);

   // Next-state for the CPU-writable registers and the sticky overrun flag.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      ie_d  = ie_q;
      sgn_d = sgn_q;
      ovr_d = ovr_q;
      if (wr_a) begin
         a_d = d_in;
      end
      if (wr_b) begin
         b_d = d_in;
      end
      if (wr_ctrl) begin
         sgn_d = mode_new;
         ie_d  = d_in[3];
      end
      // A start that collides with a running operation wins over clr_ovr.
      if (overrun) begin
         ovr_d = 1'b1;
      end else if (wr_ctrl && d_in[2]) begin
         ovr_d = 1'b0;
      end
   end

   // Next-state for the multiply FSM, datapath and the result/done pair.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      mode_d   = mode_q;
      result_d = result_q;
      done_d   = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_req) begin
               mcand_d  = PW'(mag_a);
               mplier_d = mag_b;
               acc_d    = '0;
               cnt_d    = CW'(WIDTH);
               neg_d    = neg_a ^ neg_b;
               mode_d   = mode_new;
               done_d   = 1'b0;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            // Result is only published once complete, so reads never see a
            // partial product.
            if (last_bit) begin
               result_d = result_ext;
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read mux; unmapped addresses and idle cycles return zero.
   always_comb begin
      dout_d = '0;
      if (rd_en) begin
         case (addr)
            ADDR_A:      dout_d = a_q;
            ADDR_B:      dout_d = b_q;
            ADDR_CTRL:   dout_d = {12'b0, ie_q, 1'b0, sgn_q, 1'b0};
            ADDR_STATUS: dout_d = {13'b0, ovr_q, busy, done_q};
            ADDR_RES_HI: dout_d = result_q[31:16];
            ADDR_RES_LO: dout_d = result_q[15:0];
            default:     dout_d = '0;
         endcase
      end
   end

   // Register bank update with active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q   <= '0;
         b_q   <= '0;
         ie_q  <= 1'b0;
         sgn_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         ie_q  <= ie_d;
         sgn_q <= sgn_d;
         ovr_q <= ovr_d;
      end
   end

   // Engine and result registers; reset abandons any computation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         mode_q   <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         mode_q   <= mode_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   // Registered read data: one cycle of read latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign d_out = dout_q;
   assign irq   = done_q & ie_q;

endmodule

// File: tb/tb_peripheral_mult_seq.sv
// Directed bench for peripheral_mult_seq: a 16-bit and an 8-bit instance share
// the bus; expected products come from a reference model into a scoreboard.
module tb_peripheral_mult_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] d_in;
   logic [3:0]  addr;
   logic        rd, wr;
   logic        cs16, cs8;
   logic [15:0] d_out16, d_out8;
   logic        irq16, irq8;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   peripheral_mult_seq #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut16 (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs16), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16)
   );

   peripheral_mult_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs8), .addr(addr),
      .rd(rd), .wr(wr), .d_out(d_out8), .irq(irq8)
   );

   // Reference product: mask to w bits, optionally sign-interpret, multiply.
   function automatic logic [31:0] model_mul(input int w, input bit sgn,
                                             input logic [15:0] a, input logic [15:0] b);
      longint mask, ma, mb, p;
      mask = (longint'(1) << w) - 1;
      ma = longint'(a) & mask;
      mb = longint'(b) & mask;
      if (sgn) begin
         if (ma >= (longint'(1) << (w - 1))) ma = ma - (longint'(1) << w);
         if (mb >= (longint'(1) << (w - 1))) mb = mb - (longint'(1) << w);
      end
      p = ma * mb;
      return p[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic set_cs(input bit sel, input logic v);
      if (sel) cs8 = v;
      else     cs16 = v;
   endtask

   task automatic bus_wr(input bit sel, input logic [3:0] a, input logic [15:0] d);
      set_cs(sel, 1'b1);
      wr = 1'b1; addr = a; d_in = d;
      @(posedge clk); @(negedge clk);
      set_cs(sel, 1'b0);
      wr = 1'b0;
   endtask

   task automatic bus_rd(input bit sel, input logic [3:0] a, output logic [15:0] v);
      set_cs(sel, 1'b1);
      rd = 1'b1; addr = a;
      @(posedge clk); @(negedge clk);
      set_cs(sel, 1'b0);
      rd = 1'b0;
      v = sel ? d_out8 : d_out16;
   endtask

   task automatic push_res(input string tag, input logic [31:0] r);
      exp_q.push_back(r[31:16]); tag_q.push_back({tag, "_hi"});
      exp_q.push_back(r[15:0]);  tag_q.push_back({tag, "_lo"});
   endtask

   // Read one register and compare it with the oldest scoreboard entry.
   task automatic rd_pop(input bit sel, input logic [3:0] a);
      logic [15:0] v;
      bus_rd(sel, a, v);
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $error("FAIL scoreboard_empty: observed %h expected none", v);
      end else begin
         check(tag_q.pop_front(), 32'(v), 32'(exp_q.pop_front()));
      end
   endtask

   // Hold a STATUS read; k_done is the read cycle where done is first seen.
   task automatic poll_done(input bit sel, output int k_done, output int n_busy,
                            output logic [15:0] st);
      k_done = -1; n_busy = 0; st = '0;
      set_cs(sel, 1'b1);
      rd = 1'b1; addr = 4'h6;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); @(negedge clk);
         st = sel ? d_out8 : d_out16;
         if (st[1]) n_busy++;
         if (st[0]) begin
            k_done = k;
            break;
         end
      end
      set_cs(sel, 1'b0);
      rd = 1'b0;
   endtask

   task automatic start_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] ctrl);
      bus_wr(sel, 4'h0, a);
      bus_wr(sel, 4'h2, b);
      bus_wr(sel, 4'h4, ctrl);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      logic [15:0] st;
      int          k_done, n_busy, k_irq;

      rst = 1'b0; d_in = '0; addr = '0; rd = 1'b0; wr = 1'b0; cs16 = 1'b0; cs8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Power-up state.
      check("por_dout", 32'(d_out16), 32'h0);
      check("por_irq", 32'(irq16), 32'h0);
      bus_rd(1'b0, 4'h6, v);
      check("por_status", 32'(v), 32'h0);

      // WIDTH=16 unsigned all-ones.
      start_op(1'b0, 16'hFFFF, 16'hFFFF, 16'h0001);
      push_res("u16_ffff", model_mul(16, 1'b0, 16'hFFFF, 16'hFFFF));
      poll_done(1'b0, k_done, n_busy, st);
      check("u16_busy_cycles", 32'(n_busy), 32'd16);
      check("u16_done_cycle", 32'(k_done), 32'd17);
      check("u16_status", 32'(st), 32'h0001);
      rd_pop(1'b0, 4'h8);
      rd_pop(1'b0, 4'hA);

      // WIDTH=16 signed with interrupt enable.
      start_op(1'b0, 16'hFFFD, 16'h0007, 16'h000B);
      push_res("s16_m3x7", model_mul(16, 1'b1, 16'hFFFD, 16'h0007));
      k_irq = -1;
      for (int k = 0; k <= 40; k++) begin
         if (irq16) begin
            k_irq = k;
            break;
         end
         @(posedge clk); @(negedge clk);
      end
      check("s16_irq_cycle", 32'(k_irq), 32'd16);
      rd_pop(1'b0, 4'h8);
      rd_pop(1'b0, 4'hA);
      bus_rd(1'b0, 4'h4, v);
      check("s16_ctrl_rd", 32'(v), 32'h000A);
      bus_wr(1'b0, 4'h4, 16'h0002);
      check("s16_irq_off", 32'(irq16), 32'h0);
      bus_rd(1'b0, 4'h6, v);
      check("s16_done_kept", 32'(v), 32'h0001);
      bus_rd(1'b0, 4'h4, v);
      check("s16_ctrl_rd2", 32'(v), 32'h0002);

      // Reset in the middle of a calculation.
      start_op(1'b0, 16'h1234, 16'h5678, 16'h0009);
      repeat (3) @(negedge clk);
      cs16 = 1'b1; rd = 1'b1; addr = 4'h8;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dout", 32'(d_out16), 32'h0);
      check("rst_irq", 32'(irq16), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_res_hi_rd", 32'(d_out16), 32'h0);
      cs16 = 1'b0; rd = 1'b0;
      repeat (20) @(negedge clk);
      bus_rd(1'b0, 4'h6, v);
      check("rst_status", 32'(v), 32'h0);
      push_res("rst_result", 32'h0);
      rd_pop(1'b0, 4'h8);
      rd_pop(1'b0, 4'hA);
      bus_rd(1'b0, 4'h4, v);
      check("rst_ctrl", 32'(v), 32'h0);
      check("rst_irq_after", 32'(irq16), 32'h0);

      // WIDTH=8 instance: most-negative squared, masking, sign extension.
      start_op(1'b1, 16'h0080, 16'h0080, 16'h0003);
      push_res("s8_minsq", model_mul(8, 1'b1, 16'h0080, 16'h0080));
      poll_done(1'b1, k_done, n_busy, st);
      check("s8_done_cycle", 32'(k_done), 32'd9);
      check("s8_busy_cycles", 32'(n_busy), 32'd8);
      rd_pop(1'b1, 4'h8);
      rd_pop(1'b1, 4'hA);
      start_op(1'b1, 16'h01FF, 16'h0002, 16'h0001);
      push_res("u8_mask", model_mul(8, 1'b0, 16'h01FF, 16'h0002));
      poll_done(1'b1, k_done, n_busy, st);
      check("u8_done_cycle", 32'(k_done), 32'd9);
      rd_pop(1'b1, 4'h8);
      rd_pop(1'b1, 4'hA);
      start_op(1'b1, 16'h00FD, 16'h0007, 16'h0003);
      push_res("s8_sext", model_mul(8, 1'b1, 16'h00FD, 16'h0007));
      poll_done(1'b1, k_done, n_busy, st);
      rd_pop(1'b1, 4'h8);
      rd_pop(1'b1, 4'hA);

      // Overrun: restart while busy is ignored but flagged.
      start_op(1'b0, 16'h0003, 16'h0005, 16'h0001);
      push_res("ovr_result", model_mul(16, 1'b0, 16'h0003, 16'h0005));
      @(posedge clk); @(negedge clk);
      bus_wr(1'b0, 4'h0, 16'h0009);
      bus_wr(1'b0, 4'h4, 16'h0001);
      poll_done(1'b0, k_done, n_busy, st);
      check("ovr_done_cycle", 32'(k_done), 32'd14);
      check("ovr_status", 32'(st), 32'h0005);
      rd_pop(1'b0, 4'h8);
      rd_pop(1'b0, 4'hA);
      bus_rd(1'b0, 4'h0, v);
      check("ovr_a_written", 32'(v), 32'h0009);
      bus_wr(1'b0, 4'h4, 16'h0004);
      bus_rd(1'b0, 4'h6, v);
      check("ovr_cleared", 32'(v), 32'h0001);

      // Read timing and unmapped address.
      exp_q.push_back(16'h000F); tag_q.push_back("rt_lo");
      rd_pop(1'b0, 4'hA);
      @(posedge clk); @(negedge clk);
      check("rt_dout_idle", 32'(d_out16), 32'h0);
      bus_rd(1'b0, 4'hE, v);
      check("rt_addr_e", 32'(v), 32'h0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/peripheral_mult_seq.md
Name: peripheral_mult_seq

Overview:
- Parametrised, memory-mapped sequential multiplier peripheral on the J1 16-bit I/O bus. It is the successor to the fixed 16x16 multiplier peripheral.
- Adds configurable operand width, a signed/unsigned mode, a busy status, a sticky overrun flag and an interrupt output.
- Uses an internal radix-2 shift-add datapath, one bit per cycle. It decodes the 4 LSBs of the J1 I/O address.

Parameters:
- WIDTH, 16, operand width in bits. Legal range 2..16. Operands are the low WIDTH bits of the written words.
- SIGNED_EN, 1. When 0, the signed mode bit is ignored and treated as 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset: sampled on the rising clk edge, reset when 0.
- d_in  in  16  write data from the CPU.
- cs  in  1  peripheral chip select.
- addr  in  4  register address: the 4 LSBs of j1_io_addr.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  16  registered read data.
- irq  out  1  interrupt, level; equals done AND ie.

Behaviour:
- Register map. A write takes effect only when cs&&wr; a read returns data only when cs&&rd.
  - 0x0 A (RW): A register.
  - 0x2 B (RW): B register.
  - 0x4 CTRL (W): bit0 start, bit1 signed, bit2 clr_ovr, bit3 ie. Reads of 0x4 return {12'b0, ie, 0, signed, 0}.
  - 0x6 STATUS (R): bit0 done, bit1 busy, bit2 ovr; other bits 0.
  - 0x8 RES_HI (R): result[31:16].
  - 0xA RES_LO (R): result[15:0].
  - Any other address: writes ignored, reads return 0.
- Reset (rst==0 at a rising edge): A, B, result, d_out all 0. ie=0, signed=0, done=0, busy=0, ovr=0, irq=0. FSM goes to IDLE. This applies equally mid-computation; the partial result is discarded.
- The CTRL write latches signed and ie on every write. signed is forced to 0 when SIGNED_EN=0.
- clr_ovr=1 clears ovr, unless the same write also sets it.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE with start=1:
    - Snapshot opA=A[WIDTH-1:0], opB=B[WIDTH-1:0] and the mode.
    - In signed mode, load the magnitudes and record neg = signA XOR signB.
    - Clear the accumulator and set cnt=WIDTH.
    - Set done=0, busy=1, go to CALC.
  - CALC: each cycle, if multiplier LSB=1, add the multiplicand to the accumulator. Shift, decrement cnt.
  - When the last bit has been processed, write result and go to DONE with busy=0, done=1.
    - Unsigned: result = the 2*WIDTH-bit product, zero-extended to 32 bits.
    - Signed: result = the product negated if neg, sign-extended to 32 bits.
  - DONE persists (done sticky) until the next start or reset.
- Latency: the start write occurs at edge t. busy is 1 after edges t..t+WIDTH-1. done=1 and result are valid after edge t+WIDTH.
- The result register holds its old value while in CALC. It updates atomically only at completion.
- Start while busy: ignored, the computation continues unaffected, and ovr is set to 1 (sticky).
- Writes to A/B while busy update the registers but do not affect the running operation.
- Read path: on every rising edge, d_out = (cs&&rd) ? mux(addr) : 0. This gives one-cycle read latency.
- irq follows done&ie combinationally from registers. Clearing ie drops irq without clearing done.
- Signed edge case: most-negative × most-negative produces the exact positive product; no overflow is possible in 2*WIDTH bits.

Test Plan:
1. Reset: drive rst=0 for 2 cycles mid-CALC, then release -> STATUS reads 0x0000, RES_HI/RES_LO read 0x0000, irq=0, d_out=0.
2. WIDTH=16 unsigned: A=0xFFFF, B=0xFFFF, CTRL=0x0001 -> busy=1 for exactly 16 cycles, then STATUS=0x0001, RES_HI=0xFFFE, RES_LO=0x0001.
3. WIDTH=16 signed with ie: A=0xFFFD (-3), B=0x0007, CTRL=0x000B -> irq rises 16 cycles after start, RES_HI=0xFFFF, RES_LO=0xFFEB (-21). Then write CTRL=0x0002 -> irq=0 and done stays 1.
4. WIDTH=8 instance: signed A=0x0080, B=0x0080 -> result 0x00004000 after 8 cycles. Unsigned A=0x01FF, B=0x0002 -> result 0x000001FE, showing the upper bits are masked.
5. Overrun: start A=3, B=5. Three cycles later, write CTRL=0x0001 again with A changed to 9 -> result 0x0000000F at the original completion time, STATUS=0x0005. Then CTRL=0x0004 -> STATUS=0x0001.
6. Read timing: cs&&rd at addr 0xA for one cycle -> d_out shows RES_LO on the next edge and 0 on the following edge. A read at addr 0xE returns 0.
